gestor_cubos_n: RTL and testbench
=================================

// Module: gestor_cubos_n
// PURPOSE
//  Parametrised pool manager for N falling cubes; replaces the fixed five-instance cube array.
//  Spawns cubes into free slots on a spawn pulse, rejects spawns that would overlap a cube near the top.
//  Moves active cubes once per frame and detects catch (basket) or miss (floor); counts points and misses.
//  Resolves per-pixel cube colour for the RGB mux; sits between the spawn/random logic and the VGA mux.
// PARAMETERS
//  N_CUBOS       5    number of cube slots (1..16)
//  CUBO_TAM      16   cube edge in pixels
//  SEP_MIN_X     16   minimum |dx| from any cube with y < 2*CUBO_TAM for a spawn to be accepted
//  CANASTA_Y     440  top row of basket
//  CANASTA_ANCHO 64   basket width in pixels
//  Y_FONDO       480  floor row; a cube whose y reaches it is a miss
//  PUNTOS_W      8    width of the points and misses counters
// PORTS
//  clk             in   1         system clock
//  reset           in   1         asynchronous, active-high reset
//  habilitar       in   1         game running; when low, spawn and motion are frozen
//  pulso_spawn     in   1         1-cycle request to spawn a cube
//  pos_x_nueva     in   10        x position of the new cube
//  color_nuevo     in   8         RGB332 colour of the new cube
//  velocidad_nueva in   2         new cube speed code; speed = code+1 px per frame
//  frame_tick      in   1         1-cycle pulse once per video frame
//  pixel_x         in   10        current VGA pixel x
//  pixel_y         in   10        current VGA pixel y
//  pos_x_canasta   in   10        basket left edge
//  pintar          out  1         a cube covers the pixel (registered)
//  color_pixel     out  8         colour of that cube (registered)
//  activos         out  N_CUBOS   per-slot active flags
//  spawn_rechazado out  1         1-cycle pulse: spawn dropped
//  puntos          out  PUNTOS_W  catches, saturating
//  fallos          out  PUNTOS_W  misses, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; every slot inactive with x = y = vel = color = 0. Reset takes effect immediately,
//    including in the middle of a fall.
//  - Spawn (pulso_spawn & habilitar):
//    * target = lowest-index slot inactive BEFORE the edge.
//    * Reject if no slot is free, or if any active slot has y < 2*CUBO_TAM and |x - pos_x_nueva| < SEP_MIN_X.
//    * Accept: next edge sets target x = pos_x_nueva, y = 0, vel and colour loaded, active = 1 (latency 1).
//    * Reject: no state change; spawn_rechazado = 1 for exactly that cycle.
//  - Motion (frame_tick & habilitar): every active slot computes y' = y + vel + 1 in 11 bits (no wrap).
//    * Catch: y + CUBO_TAM < CANASTA_Y, y' + CUBO_TAM >= CANASTA_Y, and x < pos_x_canasta + CANASTA_ANCHO
//      and x + CUBO_TAM > pos_x_canasta. The slot is freed and puntos += 1.
//    * Else, if y' >= Y_FONDO: the slot is freed and fallos += 1.
//    * Otherwise y <= y'.
//    * Counters add the popcount of that tick's catches/misses, clamped at 2^PUNTOS_W-1.
//  - Spawn and frame_tick in the same cycle: both apply. The new cube starts at y = 0 and does not move that tick.
//    A slot freed on this tick is not reusable until the next cycle.
//  - habilitar = 0: slots and counters hold. Pixel output still updates.
//  - Pixel: a slot hits when x <= pixel_x < x+CUBO_TAM and y <= pixel_y < y+CUBO_TAM.
//    Lowest-index hitting slot wins. pintar/color_pixel are registered 1 cycle after pixel_x/y.
//    With no hit, pintar = 0 and color_pixel = 0.
// STRUCTURE
//  - Shared include cubos_defs.vh: screen size 640x480, CUBO_TAM, CANASTA_Y, CANASTA_ANCHO, Y_FONDO, RGB332 widths.
//  - Sub-module slot_cubo, generated N_CUBOS times. It holds slot registers, load, motion, catch/miss flags and pixel hit.
//  - Parent holds: free-slot priority encoder, overlap check, saturating popcount counters, pixel priority mux.
// TESTING
//  1. Reset; spawn x=100 vel=0 color=E0 -> activos=00001 next cycle; after 3 frame_ticks y=3;
//     pixel(105,4) -> pintar=1, color_pixel=E0 one cycle later.
//  2. Spawn x=0,100,200,300,400 -> activos=11111; 6th spawn -> spawn_rechazado one cycle, activos unchanged.
//  3. Slot0 at x=110 y=0; spawn x=100 -> rejected; spawn x=126 -> accepted into slot1.
//  4. Cube x=200 vel=3, basket x=190 -> on the tick crossing y+16>=440 the slot is freed, puntos=1, fallos=0.
//  5. Basket x=500, cube x=100 -> freed when y'>=480, fallos=1.
//     Preload 255 -> stays 255; two misses on the same tick -> +2.
//  6. Slots 0,1 overlapping at the pixel -> color of slot0. Reset asserted mid-fall -> activos=0 and counters=0 immediately.
//     Spawn+frame_tick same cycle -> new y=0.

Source files
------------

// File: rtl/gestor_cubos_n_pkg.sv
// rtl/gestor_cubos_n_pkg.sv - shared screen, cube and basket constants for the falling-cube pool
package gestor_cubos_n_pkg;
    localparam int PANTALLA_ALTO     = 480;
    localparam int COORD_W           = 10;
    localparam int VEL_W             = 2;
    localparam int COLOR_W           = 8;    // RGB332
    localparam int CUBO_TAM_DEF      = 16;
    localparam int SEP_MIN_X_DEF     = 16;
    localparam int CANASTA_Y_DEF     = 440;
    localparam int CANASTA_ANCHO_DEF = 64;
    localparam int Y_FONDO_DEF       = PANTALLA_ALTO;

    function automatic logic [4:0] contar_unos(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction
endpackage

// File: rtl/gestor_cubos_n_if.sv
// rtl/gestor_cubos_n_if.sv - spawn, motion, pixel and score signals of the cube pool manager
interface gestor_cubos_n_if import gestor_cubos_n_pkg::*; #(
    parameter int N_CUBOS  = 5,
    parameter int PUNTOS_W = 8
);
    logic                 habilitar;
    logic                 pulso_spawn;
    logic [COORD_W-1:0]   pos_x_nueva;
    logic [COLOR_W-1:0]   color_nuevo;
    logic [VEL_W-1:0]     velocidad_nueva;
    logic                 frame_tick;
    logic [COORD_W-1:0]   pixel_x;
    logic [COORD_W-1:0]   pixel_y;
    logic [COORD_W-1:0]   pos_x_canasta;
    logic                 pintar;
    logic [COLOR_W-1:0]   color_pixel;
    logic [N_CUBOS-1:0]   activos;
    logic                 spawn_rechazado;
    logic [PUNTOS_W-1:0]  puntos;
    logic [PUNTOS_W-1:0]  fallos;

    modport master (
        output habilitar, pulso_spawn, pos_x_nueva, color_nuevo, velocidad_nueva,
               frame_tick, pixel_x, pixel_y, pos_x_canasta,
        input  pintar, color_pixel, activos, spawn_rechazado, puntos, fallos
    );

    modport slave (
        input  habilitar, pulso_spawn, pos_x_nueva, color_nuevo, velocidad_nueva,
               frame_tick, pixel_x, pixel_y, pos_x_canasta,
        output pintar, color_pixel, activos, spawn_rechazado, puntos, fallos
    );
endinterface

// File: rtl/gestor_cubos_n_slot_cubo.sv
// rtl/gestor_cubos_n_slot_cubo.sv - one cube slot: registers, load, per-frame fall, catch/miss and pixel hit
module slot_cubo import gestor_cubos_n_pkg::*; #(
    parameter int CUBO_TAM      = CUBO_TAM_DEF,
    parameter int CANASTA_Y     = CANASTA_Y_DEF,
    parameter int CANASTA_ANCHO = CANASTA_ANCHO_DEF,
    parameter int Y_FONDO       = Y_FONDO_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cargar,
    input  logic               mover,
    input  logic [COORD_W-1:0] x_nueva,
    input  logic [VEL_W-1:0]   vel_nueva,
    input  logic [COLOR_W-1:0] color_nuevo,
    input  logic [COORD_W-1:0] pos_x_canasta,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic               activo,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               atrapado,
    output logic               perdido,
    output logic               acierto_pixel
);
    localparam logic [11:0] TAM   = 12'(CUBO_TAM);
    localparam logic [11:0] CAN_Y = 12'(CANASTA_Y);
    localparam logic [11:0] CAN_W = 12'(CANASTA_ANCHO);
    localparam logic [11:0] FONDO = 12'(Y_FONDO);

    logic               activo_q, activo_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [VEL_W-1:0]   vel_q, vel_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [11:0]        x_ext, y_ext, y_sig, canasta_ext, px_ext, py_ext;
    logic               cruza, dentro, cae;

    always_comb begin
        x_ext       = {2'b0, x_q};
        y_ext       = {2'b0, y_q};
        canasta_ext = {2'b0, pos_x_canasta};
        px_ext      = {2'b0, pixel_x};
        py_ext      = {2'b0, pixel_y};
        // Wide enough that y + vel + 1 never wraps before the floor test.
        y_sig       = y_ext + {10'b0, vel_q} + 12'd1;
        cruza       = (y_ext + TAM < CAN_Y) && (y_sig + TAM >= CAN_Y);
        dentro      = (x_ext < canasta_ext + CAN_W) && (x_ext + TAM > canasta_ext);
        cae         = mover && activo_q;
        atrapado    = cae && cruza && dentro;
        perdido     = cae && !(cruza && dentro) && (y_sig >= FONDO);
        acierto_pixel = activo_q && (px_ext >= x_ext) && (px_ext < x_ext + TAM)
                                 && (py_ext >= y_ext) && (py_ext < y_ext + TAM);

        activo_d = activo_q;
        x_d      = x_q;
        y_d      = y_q;
        vel_d    = vel_q;
        color_d  = color_q;
        if (cargar) begin
            activo_d = 1'b1;
            x_d      = x_nueva;
            y_d      = '0;
            vel_d    = vel_nueva;
            color_d  = color_nuevo;
        end else if (atrapado || perdido) begin
            activo_d = 1'b0;
        end else if (cae) begin
            y_d = y_sig[COORD_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            activo_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            vel_q    <= '0;
            color_q  <= '0;
        end else begin
            activo_q <= activo_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            color_q  <= color_d;
        end
    end

    assign activo = activo_q;
    assign x      = x_q;
    assign y      = y_q;
    assign color  = color_q;
endmodule

// File: rtl/gestor_cubos_n.sv
// rtl/gestor_cubos_n.sv - pool of N falling cubes: spawn arbitration, scoring and per-pixel colour
module gestor_cubos_n import gestor_cubos_n_pkg::*; #(
    parameter int N_CUBOS       = 5,
    parameter int CUBO_TAM      = CUBO_TAM_DEF,
    parameter int SEP_MIN_X     = SEP_MIN_X_DEF,
    parameter int CANASTA_Y     = CANASTA_Y_DEF,
    parameter int CANASTA_ANCHO = CANASTA_ANCHO_DEF,
    parameter int Y_FONDO       = Y_FONDO_DEF,
    parameter int PUNTOS_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    gestor_cubos_n_if.slave  bus
);
    localparam logic [COORD_W:0] LIM_Y   = 11'(2 * CUBO_TAM);
    localparam logic [COORD_W:0] LIM_SEP = 11'(SEP_MIN_X);

    logic [N_CUBOS-1:0] activo_s, atrapado_s, perdido_s, acierto_s, cargar_s, libre, sel_libre;
    logic [COORD_W-1:0] x_s [N_CUBOS];
    logic [COORD_W-1:0] y_s [N_CUBOS];
    logic [COLOR_W-1:0] color_s [N_CUBOS];
    logic               mover, pedido, aceptar, solapa;
    logic [COORD_W-1:0] dx;
    logic [4:0]         n_atrapados, n_perdidos;
    logic [PUNTOS_W+4:0] suma_p, suma_f;

    logic                rechazo_q, rechazo_d, pintar_q, pintar_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic [PUNTOS_W-1:0] puntos_q, puntos_d, fallos_q, fallos_d;

    assign mover = bus.frame_tick & bus.habilitar;

    for (genvar g = 0; g < N_CUBOS; g++) begin : g_slot
        slot_cubo #(
            .CUBO_TAM      (CUBO_TAM),
            .CANASTA_Y     (CANASTA_Y),
            .CANASTA_ANCHO (CANASTA_ANCHO),
            .Y_FONDO       (Y_FONDO)
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .cargar        (cargar_s[g]),
            .mover         (mover),
            .x_nueva       (bus.pos_x_nueva),
            .vel_nueva     (bus.velocidad_nueva),
            .color_nuevo   (bus.color_nuevo),
            .pos_x_canasta (bus.pos_x_canasta),
            .pixel_x       (bus.pixel_x),
            .pixel_y       (bus.pixel_y),
            .activo        (activo_s[g]),
            .x             (x_s[g]),
            .y             (y_s[g]),
            .color         (color_s[g]),
            .atrapado      (atrapado_s[g]),
            .perdido       (perdido_s[g]),
            .acierto_pixel (acierto_s[g])
        );
    end

    always_comb begin
        libre     = ~activo_s;
        sel_libre = '0;
        for (int i = N_CUBOS - 1; i >= 0; i--) begin
            if (libre[i]) begin
                sel_libre    = '0;
                sel_libre[i] = 1'b1;
            end
        end

        // Only cubes still near the top can collide with a fresh spawn.
        solapa = 1'b0;
        dx     = '0;
        for (int i = 0; i < N_CUBOS; i++) begin
            dx = (x_s[i] >= bus.pos_x_nueva) ? x_s[i] - bus.pos_x_nueva : bus.pos_x_nueva - x_s[i];
            if (activo_s[i] && ({1'b0, y_s[i]} < LIM_Y) && ({1'b0, dx} < LIM_SEP)) begin
                solapa = 1'b1;
            end
        end

        pedido    = bus.pulso_spawn & bus.habilitar;
        aceptar   = pedido & (|libre) & ~solapa;
        cargar_s  = aceptar ? sel_libre : '0;
        rechazo_d = pedido & ~aceptar;

        n_atrapados = contar_unos(16'(atrapado_s));
        n_perdidos  = contar_unos(16'(perdido_s));
        suma_p   = {5'b0, puntos_q} + {{PUNTOS_W{1'b0}}, n_atrapados};
        suma_f   = {5'b0, fallos_q} + {{PUNTOS_W{1'b0}}, n_perdidos};
        puntos_d = (|suma_p[PUNTOS_W+4:PUNTOS_W]) ? '1 : suma_p[PUNTOS_W-1:0];
        fallos_d = (|suma_f[PUNTOS_W+4:PUNTOS_W]) ? '1 : suma_f[PUNTOS_W-1:0];

        pintar_d = |acierto_s;
        color_d  = '0;
        for (int i = N_CUBOS - 1; i >= 0; i--) begin
            if (acierto_s[i]) begin
                color_d = color_s[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rechazo_q <= 1'b0;
            pintar_q  <= 1'b0;
            color_q   <= '0;
            puntos_q  <= '0;
            fallos_q  <= '0;
        end else begin
            rechazo_q <= rechazo_d;
            pintar_q  <= pintar_d;
            color_q   <= color_d;
            puntos_q  <= puntos_d;
            fallos_q  <= fallos_d;
        end
    end

    assign bus.activos         = activo_s;
    assign bus.spawn_rechazado = rechazo_q;
    assign bus.pintar          = pintar_q;
    assign bus.color_pixel     = color_q;
    assign bus.puntos          = puntos_q;
    assign bus.fallos          = fallos_q;
endmodule

// File: tb/tb_gestor_cubos_n.sv
// tb/tb_gestor_cubos_n.sv - directed and random checks of gestor_cubos_n against a behavioural pool model
module tb_gestor_cubos_n;
    localparam int N = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gestor_cubos_n_if #(.N_CUBOS(N), .PUNTOS_W(8)) bus ();
    gestor_cubos_n #(.N_CUBOS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_asserts = 0;
    int n_fallos  = 0;

    bit m_act [N];
    int m_x [N], m_y [N], m_vel [N], m_col [N];
    int m_pts, m_fal, e_col, canasta;
    bit m_rej, e_pint;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_asserts++;
        assert (obs === esp) else begin
            n_fallos++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    function automatic logic [N-1:0] m_activos();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    task automatic modelo_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vel[i] = 0; m_col[i] = 0;
        end
        m_pts = 0; m_fal = 0; m_rej = 0; e_pint = 0; e_col = 0;
    endtask

    task automatic paso(input bit hab, input bit spw, input int x, input int col, input int vel,
                        input bit tick, input int px, input int py);
        int libre, n_atr, n_per, yn;
        bit choque;
        bus.habilitar       = hab;
        bus.pulso_spawn     = spw;
        bus.pos_x_nueva     = 10'(x);
        bus.color_nuevo     = 8'(col);
        bus.velocidad_nueva = 2'(vel);
        bus.frame_tick      = tick;
        bus.pixel_x         = 10'(px);
        bus.pixel_y         = 10'(py);
        bus.pos_x_canasta   = 10'(canasta);

        e_pint = 0; e_col = 0;
        for (int i = 0; i < N; i++)
            if (!e_pint && m_act[i] && px >= m_x[i] && px < m_x[i] + 16 && py >= m_y[i] && py < m_y[i] + 16) begin
                e_pint = 1; e_col = m_col[i];
            end

        libre = -1; choque = 0; m_rej = 0;
        if (spw && hab) begin
            for (int i = 0; i < N; i++) if (!m_act[i] && libre < 0) libre = i;
            for (int i = 0; i < N; i++)
                if (m_act[i] && m_y[i] < 32 && m_x[i] - x < 16 && x - m_x[i] < 16) choque = 1;
            if (libre < 0 || choque) begin m_rej = 1; libre = -1; end
        end

        n_atr = 0; n_per = 0;
        if (tick && hab)
            for (int i = 0; i < N; i++) if (m_act[i]) begin
                yn = m_y[i] + m_vel[i] + 1;
                if (m_y[i] + 16 < 440 && yn + 16 >= 440 && m_x[i] < canasta + 64 && m_x[i] + 16 > canasta) begin
                    m_act[i] = 0; n_atr++;
                end else if (yn >= 480) begin
                    m_act[i] = 0; n_per++;
                end else m_y[i] = yn;
            end

        if (libre >= 0) begin
            m_act[libre] = 1; m_x[libre] = x; m_y[libre] = 0; m_vel[libre] = vel; m_col[libre] = col & 255;
        end
        m_pts = (m_pts + n_atr > 255) ? 255 : m_pts + n_atr;
        m_fal = (m_fal + n_per > 255) ? 255 : m_fal + n_per;

        @(posedge clk); #1;
        comprobar("activos", 32'(bus.activos), 32'(m_activos()));
        comprobar("spawn_rechazado", 32'(bus.spawn_rechazado), 32'(m_rej));
        comprobar("puntos_fallos", {bus.puntos, bus.fallos}, {8'(m_pts), 8'(m_fal)});
        comprobar("pixel", {bus.pintar, bus.color_pixel}, {e_pint, 8'(e_col)});
    endtask

    task automatic spawn(input int x, input int col, input int vel);
        paso(1, 1, x, col, vel, 0, 0, 0);
    endtask

    task automatic tick();
        paso(1, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic mirar(input int px, input int py);
        paso(1, 0, 0, 0, 0, 0, px, py);
    endtask

    task automatic caer_todo();
        for (int k = 0; k < 200 && m_activos() != 0; k++) tick();
    endtask

    task automatic hacer_reset();
        reset = 1'b1;
        #1;
        comprobar("rst_activos", 32'(bus.activos), 32'h0);
        comprobar("rst_contadores", {bus.puntos, bus.fallos}, 32'h0);
        comprobar("rst_salidas", {bus.pintar, bus.color_pixel, bus.spawn_rechazado}, 32'h0);
        modelo_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int px, py, j;
        bus.habilitar = 0; bus.pulso_spawn = 0; bus.pos_x_nueva = 0; bus.color_nuevo = 0;
        bus.velocidad_nueva = 0; bus.frame_tick = 0; bus.pixel_x = 0; bus.pixel_y = 0;
        canasta = 500; bus.pos_x_canasta = 10'(canasta);
        #2;
        hacer_reset();

        // Single cube: spawn, three frames, pixel probe.
        spawn(100, 'hE0, 0);
        comprobar("t1_activos", 32'(bus.activos), 32'b00001);
        repeat (3) tick();
        mirar(105, 4);
        comprobar("t1_pintar", {bus.pintar, bus.color_pixel}, {1'b1, 8'hE0});
        mirar(105, 2);
        comprobar("t1_encima", 32'(bus.pintar), 32'h0);
        mirar(115, 18);
        comprobar("t1_esquina", 32'(bus.pintar), 32'h1);

        // Full pool and rejection.
        hacer_reset();
        for (int i = 0; i < 5; i++) spawn(i * 100, i + 1, 1);
        comprobar("t2_lleno", 32'(bus.activos), 32'b11111);
        spawn(500, 7, 1);
        comprobar("t2_rechazo", 32'(bus.spawn_rechazado), 32'h1);
        comprobar("t2_sin_cambio", 32'(bus.activos), 32'b11111);
        mirar(0, 0);
        comprobar("t2_pulso", 32'(bus.spawn_rechazado), 32'h0);

        // Separation near the top.
        hacer_reset();
        spawn(110, 1, 0);
        spawn(100, 2, 0);
        comprobar("t3_cerca", {bus.spawn_rechazado, 3'b0, bus.activos}, {1'b1, 3'b0, 5'b00001});
        spawn(126, 3, 0);
        comprobar("t3_limite", {bus.spawn_rechazado, 3'b0, bus.activos}, {1'b0, 3'b0, 5'b00011});

        // Catch.
        hacer_reset();
        canasta = 190;
        spawn(200, 'h1C, 3);
        caer_todo();
        comprobar("t4_atrapa", {bus.puntos, bus.fallos}, {8'd1, 8'd0});

        // Miss, then two misses on one tick.
        hacer_reset();
        canasta = 500;
        spawn(100, 'h03, 3);
        caer_todo();
        comprobar("t5_fallo", {bus.puntos, bus.fallos}, {8'd0, 8'd1});
        hacer_reset();
        spawn(0, 1, 3);
        spawn(100, 2, 3);
        caer_todo();
        comprobar("t5_doble", 32'(bus.fallos), 32'd2);

        // Saturation of the miss counter.
        hacer_reset();
        for (int r = 0; r < 52; r++) begin
            for (int i = 0; i < 5; i++) spawn(i * 100, 9, 3);
            caer_todo();
        end
        comprobar("t5_saturado", 32'(bus.fallos), 32'd255);

        // Overlap priority, simultaneous spawn+tick, reset mid-fall.
        spawn(100, 'hE0, 0);
        repeat (32) tick();
        spawn(108, 'h1C, 3);
        comprobar("t6_dos", 32'(bus.activos), 32'b00011);
        repeat (11) tick();
        mirar(110, 50);
        comprobar("t6_prioridad", {bus.pintar, bus.color_pixel}, {1'b1, 8'hE0});
        paso(1, 1, 300, 'h03, 3, 1, 0, 0);
        mirar(300, 0);
        comprobar("t6_spawn_tick", {bus.pintar, bus.color_pixel}, {1'b1, 8'h03});
        hacer_reset();

        // Random traffic against the model.
        canasta = 200;
        for (int k = 0; k < 3000; k++) begin
            j  = int'($urandom_range(0, N - 1));
            px = int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 479));
            if (m_act[j] && $urandom_range(0, 1) == 1) begin
                px = m_x[j] + int'($urandom_range(0, 17)) - 1;
                py = m_y[j] + int'($urandom_range(0, 17)) - 1;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
            end
            if ($urandom_range(0, 49) == 0) canasta = int'($urandom_range(0, 576));
            paso($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 623)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, px, py);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fallos);
        $finish;
    end
endmodule
